// File: rtl/ifu_fetch_pkg.sv
// Shared frontend types for the instruction fetch unit: sizing, the FTQ block
// descriptor and the fetch FSM state encoding.
package ifu_fetch_pkg;

  localparam int FETCH_WIDTH       = 4;
  localparam int ADDR_WIDTH        = 32;
  localparam int DATA_WIDTH        = 32;
  localparam int FRONTEND_FTQ_SIZE = 8;
  localparam int FTQ_SIZE          = FRONTEND_FTQ_SIZE;
  localparam int FTQ_ID_W          = $clog2(FTQ_SIZE);
  // length counts 0..FETCH_WIDTH inclusive, so it needs one extra code point
  localparam int LEN_W             = $clog2(FETCH_WIDTH + 1);

  typedef logic [FTQ_ID_W-1:0] ftq_id_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] start_pc;
    logic                  is_cross_cacheline;
    logic [LEN_W-1:0]      length;
  } ftq_block_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP,
    OUT
  } ifu_state_t;

  function automatic logic [FETCH_WIDTH-1:0] len_to_mask(input logic [LEN_W-1:0] len);
    logic [FETCH_WIDTH-1:0] m;
    for (int i = 0; i < FETCH_WIDTH; i++) m[i] = (LEN_W'(i) < len);
    return m;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-unit boundary: FTQ handshake, I-cache request/response and the
// instruction-buffer output. slave is the fetch unit, master its environment.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  ftq_block_t                        ftq_i;
  ftq_id_t                           ftq_id_i;
  logic                              ftq_redirect_i;
  logic                              ftq_accept_o;
  logic                              flush_i;
  logic                              icache_rreq_o;
  logic [ADDR_WIDTH-1:0]             icache_raddr_o;
  logic                              icache_cross_o;
  logic                              icache_rreq_ready_i;
  logic                              icache_rvalid_i;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] icache_rdata_i;
  logic                              ib_valid_o;
  logic [ADDR_WIDTH-1:0]             ib_pc_o;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] ib_instr_o;
  logic [FETCH_WIDTH-1:0]            ib_mask_o;
  ftq_id_t                           ib_ftq_id_o;
  logic                              ib_ready_i;

  modport slave (
    input  ftq_i, ftq_id_i, ftq_redirect_i, flush_i,
    input  icache_rreq_ready_i, icache_rvalid_i, icache_rdata_i, ib_ready_i,
    output ftq_accept_o, icache_rreq_o, icache_raddr_o, icache_cross_o,
    output ib_valid_o, ib_pc_o, ib_instr_o, ib_mask_o, ib_ftq_id_o
  );

  modport master (
    output ftq_i, ftq_id_i, ftq_redirect_i, flush_i,
    output icache_rreq_ready_i, icache_rvalid_i, icache_rdata_i, ib_ready_i,
    input  ftq_accept_o, icache_rreq_o, icache_raddr_o, icache_cross_o,
    input  ib_valid_o, ib_pc_o, ib_instr_o, ib_mask_o, ib_ftq_id_o
  );

endinterface

// File: rtl/ifu_fetch_outbuf.sv
// Single-entry output register toward the instruction buffer: loaded from the
// I-cache response, drained by ready, cleared outright by a flush.
module ifu_fetch_outbuf
  import ifu_fetch_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic                              flush,
  input  logic                              ready,
  input  logic [ADDR_WIDTH-1:0]             in_pc,
  input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] in_instr,
  input  logic [FETCH_WIDTH-1:0]            in_mask,
  input  ftq_id_t                           in_id,
  output logic                              valid,
  output logic [ADDR_WIDTH-1:0]             pc,
  output logic [FETCH_WIDTH*DATA_WIDTH-1:0] instr,
  output logic [FETCH_WIDTH-1:0]            mask,
  output ftq_id_t                           id
);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= '0;
      mask  <= '0;
      id    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= in_pc;
      instr <= in_instr;
      mask  <= in_mask;
      id    <= in_id;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: takes one FTQ block, issues one I-cache read, and
// hands the returned words to the instruction buffer, honouring kills.
module ifu_fetch
  import ifu_fetch_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ifu_fetch_if.slave bus
);

  ifu_state_t            state_q;
  logic                  accepted_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic [LEN_W-1:0]      req_len_q;
  ftq_id_t               req_id_q;

  logic accept;
  logic kill;
  logic load;

  // A block can only leave the FTQ when no request is outstanding and the
  // output slot is free or being drained this very cycle.
  assign accept = bus.ftq_i.valid & bus.icache_rreq_ready_i & ~bus.flush_i
                & ~bus.ftq_redirect_i
                & ((state_q == IDLE) | ((state_q == OUT) & bus.ib_ready_i));

  // A redirect only matters for the block taken on the previous cycle.
  assign kill = bus.flush_i | (bus.ftq_redirect_i & accepted_q);
  assign load = (state_q == WAIT) & bus.icache_rvalid_i & ~kill;

  assign bus.ftq_accept_o   = accept & rst;
  assign bus.icache_rreq_o  = accept & rst;
  assign bus.icache_raddr_o = (accept & rst) ? bus.ftq_i.start_pc : '0;
  assign bus.icache_cross_o = accept & rst & bus.ftq_i.is_cross_cacheline;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      accepted_q <= 1'b0;
      req_pc_q   <= '0;
      req_len_q  <= '0;
      req_id_q   <= '0;
    end else begin
      accepted_q <= accept;
      if (accept) begin
        req_pc_q  <= bus.ftq_i.start_pc;
        req_len_q <= bus.ftq_i.length;
        req_id_q  <= bus.ftq_id_i;
      end
      unique case (state_q)
        IDLE: if (accept) state_q <= WAIT;
        WAIT: begin
          if (bus.icache_rvalid_i) state_q <= kill ? IDLE : OUT;
          else if (kill)           state_q <= DROP;
        end
        // The killed response still has to come back before a new request.
        DROP: if (bus.icache_rvalid_i) state_q <= IDLE;
        OUT: begin
          if (bus.flush_i)         state_q <= IDLE;
          else if (accept)         state_q <= WAIT;
          else if (bus.ib_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ifu_fetch_outbuf u_outbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .flush    (bus.flush_i),
    .ready    (bus.ib_ready_i),
    .in_pc    (req_pc_q),
    .in_instr (bus.icache_rdata_i),
    .in_mask  (len_to_mask(req_len_q)),
    .in_id    (req_id_q),
    .valid    (bus.ib_valid_o),
    .pc       (bus.ib_pc_o),
    .instr    (bus.ib_instr_o),
    .mask     (bus.ib_mask_o),
    .id       (bus.ib_ftq_id_o)
  );

endmodule
